// File: rtl/cmos_rgb565_capture_if.sv
// Write port from the DVP capture stage into the SDRAM write FIFO.
// The capture stage drives this port through the master modport and the FIFO side uses the slave modport.
interface cmos_rgb565_capture_if;
  logic        sys_we;
  logic [15:0] sys_data_in;

  modport master (output sys_we, output sys_data_in);
  modport slave  (input  sys_we, input  sys_data_in);
endinterface

// File: rtl/cmos_rgb565_capture.sv
// OV7670 DVP capture: packs byte pairs into RGB565 words for the SDRAM write FIFO, in the PCLK domain.
// Optional line/frame geometry checking is built only when CAPTURE_GEOM_CHECK_EN is defined.
//
//  state     | meaning
//  WAIT_INIT | SDRAM not ready; nothing is captured
//  SKIP      | discarding the first FRAME_SKIP frames
//  ACTIVE    | frames are captured and frame_valid is high
module cmos_rgb565_capture #(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sdram_init_done,
  input  logic                         cmos_vsync,
  input  logic                         cmos_href,
  input  logic [7:0]                   cmos_data,
  cmos_rgb565_capture_if.master        fifo_wr,
  output logic                         frame_valid,
  output logic                         frame_start,
  output logic                         line_err,
  output logic                         geom_err
);

  localparam int SKIP_W = (FRAME_SKIP < 2) ? 1 : $clog2(FRAME_SKIP + 1);

  if (H_PIXELS < 1 || H_PIXELS > 1023 || V_LINES < 1 || V_LINES > 511) begin : g_bad_geom
    $error("cmos_rgb565_capture: H_PIXELS/V_LINES exceed geometry counter range");
  end

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    SKIP      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;

  logic       init_meta;
  logic       init_sync;
  logic       v_r;
  logic       v_rr;
  logic       h_r;
  logic       h_rr;
  logic [7:0] d_r;

  logic        phase;
  logic [7:0]  hi_byte;
  logic        pix_we;
  logic [15:0] pix_data;

  logic fb;
  logic h_fall;
  logic line_end;
  logic pack_en;
  logic pack_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_meta <= 1'b0;
      init_sync <= 1'b0;
      v_r       <= 1'b0;
      v_rr      <= 1'b0;
      h_r       <= 1'b0;
      h_rr      <= 1'b0;
      d_r       <= 8'h00;
    end else begin
      init_meta <= sdram_init_done;
      init_sync <= init_meta;
      v_r       <= cmos_vsync;
      v_rr      <= v_r;
      h_r       <= cmos_href;
      h_rr      <= h_r;
      d_r       <= cmos_data;
    end
  end

  assign fb        = v_r & ~v_rr;
  assign h_fall    = h_rr & ~h_r;
  // A frame boundary arriving while HREF is still high closes the line.
  assign line_end  = h_fall | (fb & h_r);
  assign pack_en   = (state == ACTIVE) && init_sync;
  assign pack_word = pack_en && !line_end && h_r && !v_r && phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_INIT;
      skip_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!init_sync) begin
        state       <= WAIT_INIT;
        skip_cnt    <= '0;
        frame_valid <= 1'b0;
      end else begin
        case (state)
          WAIT_INIT: begin
            state    <= SKIP;
            skip_cnt <= '0;
          end
          SKIP: begin
            if (fb) begin
              if (skip_cnt == SKIP_W'(FRAME_SKIP)) begin
                state       <= ACTIVE;
                frame_valid <= 1'b1;
                frame_start <= 1'b1;
              end else begin
                skip_cnt <= skip_cnt + SKIP_W'(1);
              end
            end
          end
          ACTIVE: begin
            if (fb) frame_start <= 1'b1;
          end
          default: begin
            state       <= WAIT_INIT;
            frame_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      pix_we   <= 1'b0;
      pix_data <= 16'h0000;
      line_err <= 1'b0;
    end else begin
      pix_we <= 1'b0;
      if (!pack_en) begin
        phase <= 1'b0;
      end else if (line_end) begin
        if (phase) line_err <= 1'b1;
        phase <= 1'b0;
      end else if (h_r && !v_r) begin
        if (!phase) begin
          hi_byte <= d_r;
          phase   <= 1'b1;
        end else begin
          pix_data <= {hi_byte, d_r};
          pix_we   <= 1'b1;
          phase    <= 1'b0;
        end
      end
    end
  end

  // Output stage is gated again so a word formed as init_done drops never reaches the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr.sys_we      <= 1'b0;
      fifo_wr.sys_data_in <= 16'h0000;
    end else begin
      fifo_wr.sys_we <= pix_we & pack_en;
      if (pix_we && pack_en) fifo_wr.sys_data_in <= pix_data;
    end
  end

`ifdef CAPTURE_GEOM_CHECK_EN
  logic [9:0] pix_cnt;
  logic [8:0] line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      geom_err <= 1'b0;
    end else if (fb) begin
      // The entry boundary is seen while still in SKIP, so it is never checked.
      if (pack_en && line_cnt != 9'(V_LINES)) geom_err <= 1'b1;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (pack_en) begin
      if (h_fall) begin
        if (pix_cnt != 10'(H_PIXELS)) geom_err <= 1'b1;
        pix_cnt <= '0;
        if (line_cnt != '1) line_cnt <= line_cnt + 9'd1;
      end else if (pack_word && pix_cnt != '1) begin
        pix_cnt <= pix_cnt + 10'd1;
      end
    end
  end
`else
  assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Directed bench for cmos_rgb565_capture: skip count, packing latency, odd lines, init drop, reset, geometry.
`timescale 1ns/1ps
module tb_cmos_rgb565_capture;

  localparam int FRAME_SKIP = 2;
  localparam int H_PIXELS   = 8;
  localparam int V_LINES    = 4;
`ifdef CAPTURE_GEOM_CHECK_EN
  localparam logic [31:0] GEOM_EXP = 32'd1;
`else
  localparam logic [31:0] GEOM_EXP = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       vsync;
  logic       href;
  logic [7:0] data;
  logic       frame_valid;
  logic       frame_start;
  logic       line_err;
  logic       geom_err;

  cmos_rgb565_capture_if wr_if();

  cmos_rgb565_capture #(
    .FRAME_SKIP (FRAME_SKIP),
    .H_PIXELS   (H_PIXELS),
    .V_LINES    (V_LINES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sdram_init_done (init_done),
    .cmos_vsync      (vsync),
    .cmos_href       (href),
    .cmos_data       (data),
    .fifo_wr         (wr_if),
    .frame_valid     (frame_valid),
    .frame_start     (frame_start),
    .line_err        (line_err),
    .geom_err        (geom_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int fs_cnt   = 0;
  int base;
  int snap;

  always @(negedge clk) begin
    if (wr_if.sys_we) we_cnt++;
    if (frame_start)  fs_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_vsync();
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
  endtask

  task automatic send_line(input logic [3:0] id, input int nbytes);
    href = 1'b1;
    for (int j = 0; j < nbytes; j++) begin
      data = {id, 4'(j)};
      step();
    end
    href = 1'b0;
    data = 8'h00;
    idle(4);
  endtask

  task automatic send_frame(input int lines, input int words);
    send_vsync();
    for (int l = 0; l < lines; l++) send_line(4'(l), 2 * words);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_done = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    idle(3);
    check_val("rst_we",    wr_if.sys_we,      0);
    check_val("rst_data",  wr_if.sys_data_in, 0);
    check_val("rst_fv",    frame_valid,       0);
    check_val("rst_fs",    frame_start,       0);
    check_val("rst_lerr",  line_err,          0);
    check_val("rst_gerr",  geom_err,          0);

    // skipped frames, then capture from the third boundary
    rst = 1'b0; init_done = 1'b1;
    idle(6);
    send_frame(4, 8);
    send_frame(4, 8);
    check_val("skip_we", we_cnt,      0);
    check_val("skip_fv", frame_valid, 0);
    send_vsync();
    check_val("entry_fv", frame_valid, 1);
    check_val("entry_fs", fs_cnt,      1);
    for (int l = 0; l < 4; l++) send_line(4'(l), 16);
    check_val("frame3_we",   we_cnt,            32);
    check_val("frame3_data", wr_if.sys_data_in, 32'h3E3F);
    check_val("frame3_gerr", geom_err,          0);
    check_val("frame3_lerr", line_err,          0);

    send_vsync();
    check_val("frame4_fs",   fs_cnt,   2);
    check_val("frame4_gerr", geom_err, 0);

    // short line: 7 words against H_PIXELS=8
    base = we_cnt;
    send_line(4'h5, 14);
    check_val("short_we",   we_cnt - base,     7);
    check_val("short_data", wr_if.sys_data_in, 32'h5C5D);
    check_val("short_gerr", geom_err,          GEOM_EXP);

    // single pixel latency
    base = we_cnt;
    href = 1'b1; data = 8'hF8;
    step();
    data = 8'h1F;
    step();
    href = 1'b0; data = 8'h00;
    check_val("lat_1clk", wr_if.sys_we, 0);
    step();
    check_val("lat_2clk", wr_if.sys_we, 0);
    step();
    check_val("lat_3clk_we",   wr_if.sys_we,      1);
    check_val("lat_3clk_data", wr_if.sys_data_in, 32'hF81F);
    step();
    check_val("lat_4clk_we",   wr_if.sys_we,      0);
    check_val("lat_hold_data", wr_if.sys_data_in, 32'hF81F);
    idle(3);
    check_val("lat_count", we_cnt - base, 1);
    check_val("lat_lerr",  line_err,      0);

    // odd byte line
    base = we_cnt;
    send_line(4'h6, 5);
    check_val("odd_we",   we_cnt - base,     2);
    check_val("odd_data", wr_if.sys_data_in, 32'h6263);
    check_val("odd_lerr", line_err,          1);
    idle(10);
    check_val("odd_lerr_hold", line_err, 1);

    // init_done dropped mid-line
    href = 1'b1;
    for (int j = 0; j < 6; j++) begin
      data = {4'h7, 4'(j)};
      step();
    end
    init_done = 1'b0;
    for (int j = 6; j < 8; j++) begin
      data = {4'h7, 4'(j)};
      step();
    end
    check_val("drop_fv_2clk", frame_valid, 1);
    data = 8'h78;
    step();
    check_val("drop_fv_3clk", frame_valid, 0);
    snap = we_cnt;
    for (int j = 9; j < 19; j++) begin
      data = {4'h7, 4'(j)};
      step();
    end
    href = 1'b0; data = 8'h00;
    idle(4);
    check_val("drop_we",   we_cnt,   snap);
    check_val("drop_lerr", line_err, 1);

    init_done = 1'b1;
    idle(6);
    send_frame(1, 8);
    send_frame(1, 8);
    check_val("reskip_fv", frame_valid, 0);
    check_val("reskip_we", we_cnt,      snap);
    send_vsync();
    check_val("reentry_fv", frame_valid, 1);
    base = we_cnt;
    send_line(4'h0, 16);
    check_val("reentry_we", we_cnt - base, 8);

    // one-cycle reset mid-line
    href = 1'b1;
    for (int j = 0; j < 3; j++) begin
      data = {4'h9, 4'(j)};
      step();
    end
    rst = 1'b1;
    step();
    check_val("midrst_we",   wr_if.sys_we,      0);
    check_val("midrst_data", wr_if.sys_data_in, 0);
    check_val("midrst_fv",   frame_valid,       0);
    check_val("midrst_lerr", line_err,          0);
    check_val("midrst_gerr", geom_err,          0);
    rst = 1'b0; href = 1'b0; data = 8'h00;
    idle(6);
    base = we_cnt;
    send_frame(1, 8);
    send_frame(1, 8);
    check_val("rst_skip_fv", frame_valid,   0);
    check_val("rst_skip_we", we_cnt - base, 0);
    send_vsync();
    check_val("rst_entry_fv", frame_valid, 1);
    send_line(4'h1, 16);
    check_val("rst_entry_we",   we_cnt - base,     8);
    check_val("rst_entry_data", wr_if.sys_data_in, 32'h1E1F);
    check_val("rst_entry_lerr", line_err,          0);
    check_val("rst_entry_gerr", geom_err,          0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
